// File: rtl/frq_pw_mc_gen.sv
// frq_pw_mc_gen
// Multi-channel sounding clock and pulse generator. Divides clk250 into a
// one-cycle sounding tick (clk_znd) and drives CH transmitter pulses, each
// with its own delay and width. Runs continuously or in triggered bursts.
//
// Ports
//   clk250    in   system clock, rising edge
//   rst       in   synchronous active-high reset
//   en        in   global enable
//   mode      in   0 = continuous, 1 = burst
//   start     in   burst trigger (level-sampled)
//   frq_div   in   tick period = frq_div+1 cycles
//   burst_len in   ticks per burst (0 = start ignored)
//   pw        in   per-channel width fields, high time = pw_c+1 cycles
//   dly       in   per-channel delay fields
//   clk_znd   out  one-cycle sounding tick
//   pulse     out  registered transmitter pulses
//   busy      out  burst in progress
//   done      out  one-cycle end-of-burst strobe
//   overrun   out  sticky per-channel restart flag
module frq_pw_mc_gen #(
  parameter int CH    = 4,
  parameter int DIV_W = 8,
  parameter int PW_W  = 8,
  parameter int DLY_W = 8,
  parameter int BST_W = 8
) (
  input  logic                clk250,
  input  logic                rst,
  input  logic                en,
  input  logic                mode,
  input  logic                start,
  input  logic [DIV_W-1:0]    frq_div,
  input  logic [BST_W-1:0]    burst_len,
  input  logic [CH*PW_W-1:0]  pw,
  input  logic [CH*DLY_W-1:0] dly,
  output logic                clk_znd,
  output logic [CH-1:0]       pulse,
  output logic                busy,
  output logic                done,
  output logic [CH-1:0]       overrun
);

  localparam int CW = (PW_W > DLY_W) ? PW_W : DLY_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DELAY = 2'd1,
    ST_HIGH  = 2'd2
  } ch_state_t;

  logic [DIV_W-1:0] r_cnt;
  logic [DIV_W-1:0] r_per;
  logic [BST_W-1:0] r_rem;
  logic             r_busy;
  logic             r_done;
  logic             r_clk_znd;
  ch_state_t        r_st  [CH];
  logic [CW-1:0]    r_ctr [CH];
  logic [CH-1:0]    r_pulse;
  logic [CH-1:0]    r_ovr;

  logic w_tk;
  logic w_accept;
  logic w_last;

  // Tick, burst acceptance and last-tick decode
  always_comb begin
    // While a burst is running the mode input is ignored; otherwise only
    // continuous mode lets the divider produce ticks.
    w_tk     = en & (r_busy | ~mode) & (r_cnt == r_per);
    w_accept = start & en & ~r_busy & mode & (burst_len != {BST_W{1'b0}});
    w_last   = (r_rem == {{(BST_W-1){1'b0}}, 1'b1});
  end

  // Divider, burst sequencing and sounding-tick register
  always_ff @(posedge clk250) begin
    if (rst) begin
      r_cnt     <= {DIV_W{1'b0}};
      r_per     <= frq_div;
      r_rem     <= {BST_W{1'b0}};
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_clk_znd <= 1'b0;
    end else begin
      r_clk_znd <= w_tk;
      r_done    <= 1'b0;
      if (w_accept) begin
        // Preload cnt to the period so the first tick lands next cycle.
        r_cnt  <= frq_div;
        r_per  <= frq_div;
        r_rem  <= burst_len;
        r_busy <= 1'b1;
      end else if (r_busy) begin
        if (!en) begin
          // Abort: no done strobe.
          r_busy <= 1'b0;
          r_cnt  <= {DIV_W{1'b0}};
          r_per  <= frq_div;
          r_rem  <= {BST_W{1'b0}};
        end else if (w_tk) begin
          r_cnt <= {DIV_W{1'b0}};
          r_rem <= r_rem - {{(BST_W-1){1'b0}}, 1'b1};
          if (w_last) begin
            r_busy <= 1'b0;
            r_done <= 1'b1;
            r_per  <= frq_div;
          end
        end else begin
          r_cnt <= r_cnt + {{(DIV_W-1){1'b0}}, 1'b1};
        end
      end else if (en && !mode) begin
        if (w_tk) begin
          r_cnt <= {DIV_W{1'b0}};
          r_per <= frq_div;
        end else begin
          r_cnt <= r_cnt + {{(DIV_W-1){1'b0}}, 1'b1};
        end
      end else begin
        // Idle divider: period follows frq_div so a restart uses the live value.
        r_cnt <= {DIV_W{1'b0}};
        r_per <= frq_div;
      end
    end
  end

  // Per-channel delay/high FSMs, pulse output stage and sticky overrun
  always_ff @(posedge clk250) begin
    if (rst) begin
      for (int c = 0; c < CH; c++) begin
        r_st[c]  <= ST_IDLE;
        r_ctr[c] <= {CW{1'b0}};
      end
      r_pulse <= {CH{1'b0}};
      r_ovr   <= {CH{1'b0}};
    end else begin
      for (int c = 0; c < CH; c++) begin
        // State is the first delay stage; this register is the second.
        r_pulse[c] <= (r_st[c] == ST_HIGH);
        if (w_tk) begin
          // A tick always restarts the channel; HIGH->HIGH keeps the pulse solid.
          if (r_st[c] != ST_IDLE) begin
            r_ovr[c] <= 1'b1;
          end
          r_ctr[c] <= {CW{1'b0}};
          if (dly[c*DLY_W +: DLY_W] == {DLY_W{1'b0}}) begin
            r_st[c] <= ST_HIGH;
          end else begin
            r_st[c] <= ST_DELAY;
          end
        end else begin
          case (r_st[c])
            ST_DELAY: begin
              if (r_ctr[c] == CW'(dly[c*DLY_W +: DLY_W] - {{(DLY_W-1){1'b0}}, 1'b1})) begin
                r_st[c]  <= ST_HIGH;
                r_ctr[c] <= {CW{1'b0}};
              end else begin
                r_ctr[c] <= r_ctr[c] + {{(CW-1){1'b0}}, 1'b1};
              end
            end
            ST_HIGH: begin
              if (r_ctr[c] == CW'(pw[c*PW_W +: PW_W])) begin
                r_st[c]  <= ST_IDLE;
                r_ctr[c] <= {CW{1'b0}};
              end else begin
                r_ctr[c] <= r_ctr[c] + {{(CW-1){1'b0}}, 1'b1};
              end
            end
            default: begin
              r_st[c]  <= ST_IDLE;
              r_ctr[c] <= {CW{1'b0}};
            end
          endcase
        end
      end
    end
  end

  assign clk_znd = r_clk_znd;
  assign pulse   = r_pulse;
  assign busy    = r_busy;
  assign done    = r_done;
  assign overrun = r_ovr;

endmodule

// File: tb/tb_frq_pw_mc_gen.sv
module tb_frq_pw_mc_gen;

  localparam int CH = 4;

  logic        clk250 = 1'b0;
  logic        rst;
  logic        en;
  logic        mode;
  logic        start;
  logic [7:0]  frq_div;
  logic [7:0]  burst_len;
  logic [31:0] pw;
  logic [31:0] dly;
  logic        clk_znd;
  logic [3:0]  pulse;
  logic        busy;
  logic        done;
  logic [3:0]  overrun;

  int checks = 0;
  int errors = 0;

  // Reference model state: tick times and channel timing by arithmetic
  int       cyc;
  int       nt;
  int       per_m;
  int       rem_m;
  bit       busy_m;
  bit       run_prev;
  bit       have_l;
  int       last_t;
  logic [3:0] ovr_m;
  int       fd_prev;
  int       d_m [CH];
  int       p_m [CH];

  frq_pw_mc_gen #(
    .CH(4), .DIV_W(8), .PW_W(8), .DLY_W(8), .BST_W(8)
  ) dut (
    .clk250    (clk250),
    .rst       (rst),
    .en        (en),
    .mode      (mode),
    .start     (start),
    .frq_div   (frq_div),
    .burst_len (burst_len),
    .pw        (pw),
    .dly       (dly),
    .clk_znd   (clk_znd),
    .pulse     (pulse),
    .busy      (busy),
    .done      (done),
    .overrun   (overrun)
  );

  always #2 clk250 = ~clk250;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic set_ch(input int d0, input int d1, input int d2, input int d3,
                        input int p0, input int p1, input int p2, input int p3);
    d_m[0] = d0; d_m[1] = d1; d_m[2] = d2; d_m[3] = d3;
    p_m[0] = p0; p_m[1] = p1; p_m[2] = p2; p_m[3] = p3;
    for (int c = 0; c < CH; c++) begin
      dly[c*8 +: 8] = 8'(d_m[c]);
      pw[c*8 +: 8]  = 8'(p_m[c]);
    end
  endtask

  // One clock cycle: apply inputs, predict, clock, compare.
  task automatic step(input logic r, input logic e, input logic m, input logic s,
                      input logic [7:0] f, input logic [7:0] bl);
    logic       tk_m;
    logic       done_n;
    bit         run_now;
    logic [3:0] pul_m;
    rst = r; en = e; mode = m; start = s; frq_div = f; burst_len = bl;
    tk_m = 1'b0; done_n = 1'b0; run_now = 1'b0; pul_m = 4'b0000;
    if (r) begin
      busy_m = 1'b0; rem_m = 0; have_l = 1'b0; ovr_m = 4'b0000;
    end else begin
      // pulse in the next cycle follows the latest tick at least two cycles old
      for (int c = 0; c < CH; c++) begin
        if (have_l && (cyc + 1 >= last_t + 2 + d_m[c]) &&
            (cyc + 1 <= last_t + 2 + d_m[c] + p_m[c])) begin
          pul_m[c] = 1'b1;
        end
      end
      if (busy_m) begin
        if (!e) begin
          busy_m = 1'b0;
        end else if (cyc == nt) begin
          tk_m  = 1'b1;
          rem_m = rem_m - 1;
          if (rem_m == 0) begin
            busy_m = 1'b0;
            done_n = 1'b1;
          end else begin
            nt = cyc + per_m + 1;
          end
        end
      end else if (e && !m) begin
        run_now = 1'b1;
        if (!run_prev) nt = cyc + fd_prev;
        if (cyc == nt) begin
          tk_m = 1'b1;
          nt   = cyc + int'(f) + 1;
        end
      end else if (e && m && s && (bl != 8'd0)) begin
        busy_m = 1'b1;
        rem_m  = int'(bl);
        per_m  = int'(f);
        nt     = cyc + 1;
      end
      if (tk_m) begin
        for (int c = 0; c < CH; c++) begin
          if (have_l && (cyc - last_t <= d_m[c] + p_m[c] + 1)) ovr_m[c] = 1'b1;
        end
        last_t = cyc;
        have_l = 1'b1;
      end
    end
    run_prev = run_now;
    fd_prev  = int'(f);
    @(posedge clk250);
    #1;
    chk("clk_znd", 32'(clk_znd), 32'(tk_m));
    chk("busy",    32'(busy),    32'(busy_m));
    chk("done",    32'(done),    32'(done_n));
    chk("pulse",   32'(pulse),   32'(pul_m));
    chk("overrun", 32'(overrun), 32'(ovr_m));
    cyc++;
  endtask

  initial begin
    int prev_z;
    int nz;
    int nd;
    int ivl [$];
    cyc = 0; nt = 0; per_m = 0; rem_m = 0; busy_m = 1'b0; run_prev = 1'b0;
    have_l = 1'b0; last_t = 0; ovr_m = 4'b0000; fd_prev = 0;
    rst = 1'b1; en = 1'b0; mode = 1'b0; start = 1'b0; frq_div = 8'd9; burst_len = 8'd0;
    set_ch(0, 0, 0, 0, 0, 0, 0, 0);

    // Reset state
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 8'd9, 8'd0);
    chk("rst_outputs", 32'({clk_znd, busy, done, pulse, overrun}), 32'd0);

    // Continuous, four channel timings, ch3 overlapping itself
    set_ch(0, 1, 5, 0, 0, 3, 2, 9);
    step(1'b1, 1'b1, 1'b0, 1'b0, 8'd9, 8'd0);
    prev_z = -1;
    for (int k = 0; k < 45; k++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, 8'd9, 8'd0);
      if (clk_znd) begin
        if (prev_z >= 0) chk("tp1_period", 32'(k - prev_z), 32'd10);
        prev_z = k;
      end
    end
    chk("tp1_overrun", 32'(overrun), 32'(4'b1000));

    // Burst of 3, second start held during busy
    set_ch(0, 1, 2, 0, 1, 0, 1, 2);
    step(1'b1, 1'b0, 1'b1, 1'b0, 8'd4, 8'd3);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 1'b1, 1'b0, 8'd4, 8'd3);
    nz = 0; nd = 0;
    for (int k = 0; k < 12; k++) begin
      step(1'b0, 1'b1, 1'b1, 1'b1, 8'd4, 8'd3);
      if (clk_znd) nz++;
      if (done) nd++;
    end
    chk("tp2_znd_cnt", 32'(nz), 32'd3);
    chk("tp2_done_cnt", 32'(nd), 32'd1);
    for (int k = 0; k < 20; k++) step(1'b0, 1'b1, 1'b1, 1'b0, 8'd4, 8'd3);

    // frq_div 9 -> 3 mid-period
    step(1'b1, 1'b1, 1'b0, 1'b0, 8'd9, 8'd0);
    for (int k = 0; k < 12; k++) step(1'b0, 1'b1, 1'b0, 1'b0, 8'd9, 8'd0);
    prev_z = 9;
    for (int k = 12; k < 40; k++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, 8'd3, 8'd0);
      if (clk_znd) begin
        ivl.push_back(k - prev_z);
        prev_z = k;
      end
    end
    chk("tp3_n_ticks", 32'(ivl.size() >= 3), 32'd1);
    if (ivl.size() >= 2) begin
      chk("tp3_first_ivl", 32'(ivl[0]), 32'd10);
      chk("tp3_second_ivl", 32'(ivl[1]), 32'd4);
    end

    // en dropped mid-burst with a pulse in progress
    set_ch(2, 0, 0, 0, 4, 0, 0, 0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 8'd6, 8'd5);
    step(1'b0, 1'b1, 1'b1, 1'b1, 8'd6, 8'd5);
    step(1'b0, 1'b1, 1'b1, 1'b0, 8'd6, 8'd5);
    step(1'b0, 1'b1, 1'b1, 1'b0, 8'd6, 8'd5);
    nz = 0; nd = 0;
    for (int k = 0; k < 25; k++) begin
      step(1'b0, 1'b0, 1'b1, 1'b0, 8'd6, 8'd5);
      if (clk_znd) nz++;
      if (done) nd++;
    end
    chk("tp4_znd_after_abort", 32'(nz), 32'd0);
    chk("tp4_no_done", 32'(nd), 32'd0);

    // burst_len == 0 ignored
    nz = 0;
    for (int k = 0; k < 10; k++) begin
      step(1'b0, 1'b1, 1'b1, 1'b1, 8'd4, 8'd0);
      if (busy || done || clk_znd) nz++;
    end
    chk("tp5_bl0_idle", 32'(nz), 32'd0);

    // frq_div = 0 continuous: stuck-high tick and pulses
    set_ch(0, 0, 0, 0, 0, 0, 0, 0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0);
    for (int k = 0; k < 10; k++) step(1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0);
    chk("tp5_znd_high", 32'(clk_znd), 32'd1);
    chk("tp5_pulse_high", 32'(pulse), 32'(4'b1111));
    chk("tp5_overrun", 32'(overrun), 32'(4'b1111));

    // Reset mid-pulse together with start
    set_ch(0, 1, 0, 0, 9, 3, 9, 9);
    step(1'b1, 1'b1, 1'b0, 1'b0, 8'd9, 8'd3);
    for (int k = 0; k < 24; k++) step(1'b0, 1'b1, 1'b0, 1'b0, 8'd9, 8'd3);
    step(1'b1, 1'b1, 1'b1, 1'b1, 8'd9, 8'd3);
    chk("tp6_rst_outputs", 32'({clk_znd, busy, done, pulse, overrun}), 32'd0);
    for (int k = 0; k < 5; k++) step(1'b0, 1'b1, 1'b1, 1'b0, 8'd9, 8'd3);

    // Randomized segments
    for (int sgm = 0; sgm < 20; sgm++) begin
      logic       e_r;
      logic       m_r;
      logic [7:0] f_r;
      set_ch($urandom_range(0, 6), $urandom_range(0, 6), $urandom_range(0, 6), $urandom_range(0, 6),
             $urandom_range(0, 6), $urandom_range(0, 6), $urandom_range(0, 6), $urandom_range(0, 6));
      f_r = 8'($urandom_range(0, 7));
      m_r = 1'($urandom_range(0, 1));
      step(1'b1, 1'b1, m_r, 1'b0, f_r, 8'd2);
      for (int k = 0; k < 150; k++) begin
        if ($urandom_range(0, 19) == 0) f_r = 8'($urandom_range(0, 7));
        if ($urandom_range(0, 24) == 0) m_r = ~m_r;
        e_r = ($urandom_range(0, 29) != 0);
        step(1'b0, e_r, m_r, 1'($urandom_range(0, 3) == 0), f_r, 8'($urandom_range(0, 4)));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/frq_pw_mc_gen.md
# frq_pw_mc_gen

Multi-channel sounding clock and pulse generator: successor to the single-channel frequency/pulse-width block. It divides clk250 into a sounding tick, `clk_znd`, and drives CH transmitter pulse outputs. Each channel has its own pulse delay and width and a sticky overrun flag. It runs either continuously or in triggered bursts of N ticks. It sits between the control register file and the transmitter drivers.

## Interface
Parameters:
- CH, 4: number of pulse channels (1..16)
- DIV_W, 8: width of `frq_div`
- PW_W, 8: per-channel width field
- DLY_W, 8: per-channel delay field
- BST_W, 8: width of `burst_len`

Ports:
- clk250  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- en  in  1  global enable
- mode  in  1  0 = continuous, 1 = burst
- start  in  1  burst trigger, level-sampled
- frq_div  in  DIV_W  tick period = frq_div+1 cycles
- burst_len  in  BST_W  ticks per burst
- pw  in  CH*PW_W  channel c width field at [c*PW_W +: PW_W]; high time = pw_c+1 cycles
- dly  in  CH*DLY_W  channel c delay field at [c*DLY_W +: DLY_W]
- clk_znd  out  1  one-cycle sounding tick
- pulse  out  CH  transmitter pulses, registered
- busy  out  1  burst in progress
- done  out  1  one-cycle end-of-burst strobe
- overrun  out  CH  sticky: a tick arrived while the channel was not IDLE

## Operation
- Divider:
  - Counter `cnt` (DIV_W bits) and latched period `per`.
  - Internal tick `tk` fires when `cnt == per`; `cnt` then returns to 0 and `per` reloads from `frq_div`.
  - A `frq_div` change therefore takes effect on the next period.
- Continuous mode (`mode=0`):
  - While `en=1`, the divider runs freely.
  - While `en=0`, `cnt` is held at 0, `per` tracks `frq_div`, and no ticks are generated.
- Burst mode (`mode=1`):
  - A start is accepted when `start & en & ~busy`.
  - On acceptance, `per` and `mode` are latched, `rem` is set to `burst_len`, and `busy` is set.
  - `tk` fires on the cycle after acceptance. Further ticks follow every `per+1` cycles; `rem` decrements on each tick.
  - When the tick that brings `rem` to 0 fires, `busy` clears on the next cycle and `done` pulses for that one cycle.
  - `burst_len == 0`: `start` is ignored (no busy, no done).
  - `en` falling mid-burst aborts the burst: `busy` clears and no `done` is issued.
  - `mode` or `burst_len` changes during a burst are ignored.
  - While `busy=0`, the divider is idle.
- Channel FSM, one per channel: IDLE → DELAY → HIGH → IDLE.
  - On `tk`: if `dly_c == 0`, enter HIGH; otherwise enter DELAY with the counter at 0.
  - DELAY: count until the counter equals `dly_c − 1`, then enter HIGH.
  - HIGH: internal pulse is 1; count until the counter equals `pw_c`, then return to IDLE.
  - `pw_c` and `dly_c` are sampled live.
  - `tk` in DELAY or HIGH restarts the channel as above and sets `overrun[c]`. The pulse stays continuous and does not glitch low.
  - `en=0` does not abort channels already in DELAY or HIGH; they complete.
- Output pipeline:
  - `clk_znd` = `tk` delayed 1 register.
  - `pulse` = internal HIGH delayed 2 registers.
  - This matches the legacy clk_znd-to-pulse skew.

## Timing
- Reset: `clk_znd`, `pulse`, `busy`, `done`, `overrun` = 0; `cnt` = 0; `rem` = 0; all channels IDLE; the pipeline is cleared.
- Reset has priority over every input, including `start` in the same cycle.
- `tk` at cycle t → `clk_znd` = 1 at t+1 only.
- `pulse[c]` rises at t+2+dly_c and is high for exactly pw_c+1 cycles, absent a restart.
- Continuous mode: consecutive `clk_znd` rising edges are frq_div+1 cycles apart.
  - First tick after `en` rises (or after reset with `en=1`) is at cycle frq_div.
  - `frq_div=0` gives `clk_znd` constantly high.
- Burst mode, `start` accepted at cycle s:
  - `busy` = 1 from s+1.
  - `clk_znd` at s+2, then every per+1 cycles.
  - `done` = 1 on the cycle after the last `tk`, which is also the cycle of the last `clk_znd`; `busy` = 0 from that cycle.
  - A new `start` is accepted in the same cycle `done` is high.
- Widths: `cnt`, `rem`, and the channel counters never wrap; all compares are equality on unsigned values.

## Test plan
- Continuous, frq_div=9, CH=4, dly={0,1,5,0}, pw={0,3,2,9} → `clk_znd` every 10 cycles. Ch0 1-cycle pulse at +2, ch1 4 cycles at +3, ch2 3 cycles at +7, ch3 10 cycles, continuous high with `overrun[3]` set; ch0–2 overrun = 0.
- Burst, burst_len=3, frq_div=4, start at s → `clk_znd` at s+2, s+7, s+12. `done` at s+12, `busy` high for s+1..s+11. A second start held high during busy is ignored until s+12.
- frq_div changed 9→3 mid-period → current period completes at 10 cycles, following periods are 4 cycles.
- `en` dropped mid-burst (after the 1st of 5 ticks) → no further `clk_znd`, `busy`=0 next cycle, `done` never asserted, ch pulse in progress completes.
- burst_len=0 with start → no `busy`, `done`, or `clk_znd`; frq_div=0 continuous → `clk_znd` stuck high, pw=0 pulses stuck high with overrun set.
- `rst` asserted mid-pulse and simultaneously with start → all outputs 0 next cycle, start not accepted, `overrun` cleared.
